// File: rtl/rr_arb_pkg.sv
// Shared widths, request field offsets and the response-pipe entry type for the
// round-robin bank arbiter.
package rr_arb_pkg;

  localparam int VALID_BIT = 0;
  localparam int WR_BIT    = 1;
  localparam int MAX_ID_W  = 8;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } pipe_entry_t;

  function automatic int num_bank_bits(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 0;
  endfunction

  function automatic int req_width(input int aw, input int vw);
    return aw + vw + 2;
  endfunction

  function automatic int plm_input_width(input int aw, input int nbanks, input int vw);
    return aw - num_bank_bits(nbanks) + vw + 1;
  endfunction

endpackage

// File: rtl/rr_bank_arbiter_if.sv
// Consumer and PLM-facing bundle of the bank arbiter; grant_count exists only
// when RR_ARB_STATS_EN is defined.
interface rr_bank_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 4,
  parameter int NBANKS      = 2,
  parameter int NPORTS      = 1
);
  localparam int REQ_W    = req_width(ADDR_WIDTH, VALUE_WIDTH);
  localparam int PIN_W    = plm_input_width(ADDR_WIDTH, NBANKS, VALUE_WIDTH);
  localparam int NKERNELS = NBANKS * NPORTS;

  // Handshake: a consumer holds requests[c] (valid=1) until grants[c] is high;
  // the request is consumed in that same cycle.
  logic [REQ_W-1:0]       requests       [NCONSUMERS];
  logic [NCONSUMERS-1:0]  grants;
  logic [NKERNELS-1:0]    plm_en;
  logic [PIN_W-1:0]       plm_inputs     [NKERNELS];
  logic [VALUE_WIDTH-1:0] plm_outputs    [NKERNELS];
  logic [VALUE_WIDTH-1:0] responses      [NCONSUMERS];
  logic [NCONSUMERS-1:0]  response_valid;
`ifdef RR_ARB_STATS_EN
  logic [15:0]            grant_count    [NKERNELS];

  modport slave  (input  requests, plm_outputs,
                  output grants, plm_en, plm_inputs, responses, response_valid, grant_count);
  modport master (output requests, plm_outputs,
                  input  grants, plm_en, plm_inputs, responses, response_valid, grant_count);
`else
  modport slave  (input  requests, plm_outputs,
                  output grants, plm_en, plm_inputs, responses, response_valid);
  modport master (output requests, plm_outputs,
                  input  grants, plm_en, plm_inputs, responses, response_valid);
`endif

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority find-first: first set bit of elig at or after pivot, mod N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] pivot,
  output logic [$clog2(N)-1:0] win,
  output logic                 found
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [IW:0] idx;

  // One extra bit holds pivot+i before the explicit wrap, so non-power-of-2 N works.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, pivot} + (IW+1)'(i);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!found && elig[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_bank_arbiter.sv
// Round-robin arbiter from NCONSUMERS request streams onto NBANKS x NPORTS PLM
// ports, with read-data return. Optional grant counters: RR_ARB_STATS_EN.
module rr_bank_arbiter
  import rr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 4,
  parameter int NBANKS      = 2,
  parameter int NPORTS      = 1,
  parameter int PLM_LATENCY = 1
) (
  input logic              clk,
  input logic              reset_n,
  rr_bank_arbiter_if.slave bus
);
  localparam int NKERNELS = NBANKS * NPORTS;
  localparam int NBB      = num_bank_bits(NBANKS);
  localparam int BW       = (NBB > 0) ? NBB : 1;
  localparam int IW       = $clog2(NCONSUMERS);
  localparam int REQ_W    = req_width(ADDR_WIDTH, VALUE_WIDTH);
  localparam int PIN_W    = plm_input_width(ADDR_WIDTH, NBANKS, VALUE_WIDTH);

  logic [NCONSUMERS-1:0] req_valid, req_wr;
  logic [BW-1:0]         req_bank [NCONSUMERS];
  logic [PIN_W-1:0]      req_pin  [NCONSUMERS];

  // {local_addr, value, wr} sits contiguously just below the bank bits.
  always_comb begin
    for (int c = 0; c < NCONSUMERS; c++) begin
      req_valid[c] = bus.requests[c][VALID_BIT];
      req_wr[c]    = bus.requests[c][WR_BIT];
      req_pin[c]   = bus.requests[c][PIN_W:1];
      req_bank[c]  = (NBANKS > 1) ? bus.requests[c][REQ_W-1 -: BW] : '0;
    end
  end

  logic [NKERNELS-1:0][NCONSUMERS-1:0] gvec_all;
  logic [NKERNELS-1:0]                 exit_v;
  logic [NKERNELS-1:0][MAX_ID_W-1:0]   exit_id;

  for (genvar k = 0; k < NKERNELS; k++) begin : g_kern
    localparam int B = k / NPORTS;
    localparam int P = k % NPORTS;
    localparam logic [IW-1:0] PIVOT_RST = IW'((B + P * (NCONSUMERS / NPORTS)) % NCONSUMERS);

    logic [NCONSUMERS-1:0] match, taken, elig, gvec;
    logic [IW-1:0]         win, pivot_q, pivot_d;
    logic                  found, found_g;
    logic [PIN_W-1:0]      pin;
    pipe_entry_t           pipe_q [PLM_LATENCY];
    pipe_entry_t           pipe_d [PLM_LATENCY];

    always_comb begin
      for (int c = 0; c < NCONSUMERS; c++)
        match[c] = req_valid[c] && (req_bank[c] == BW'(B));
    end

    // Lower-numbered ports of the same bank claim consumers first.
    if (P == 0) begin : g_first
      assign taken = '0;
    end else begin : g_chain
      assign taken = g_kern[k-1].taken | g_kern[k-1].gvec;
    end

    assign elig = match & ~taken;

    rr_pick #(.N(NCONSUMERS)) u_pick (
      .elig  (elig),
      .pivot (pivot_q),
      .win   (win),
      .found (found)
    );

    assign found_g     = found & reset_n;
    assign gvec        = found_g ? (NCONSUMERS'(1) << win) : '0;
    assign gvec_all[k] = gvec;

    always_comb begin
      pin     = '0;
      pivot_d = pivot_q;
      if (found_g) begin
        pin     = req_pin[win];
        pivot_d = (win == IW'(NCONSUMERS - 1)) ? '0 : win + IW'(1);
      end
    end

    assign bus.plm_en[k]     = found_g;
    assign bus.plm_inputs[k] = pin;

    always_comb begin
      pipe_d[0].valid = found_g && !req_wr[win];
      pipe_d[0].id    = MAX_ID_W'(win);
      for (int i = 1; i < PLM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pivot_q <= PIVOT_RST;
        for (int i = 0; i < PLM_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
        pivot_q <= pivot_d;
        for (int i = 0; i < PLM_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      end
    end

    assign exit_v[k]  = pipe_q[PLM_LATENCY-1].valid;
    assign exit_id[k] = pipe_q[PLM_LATENCY-1].id;

`ifdef RR_ARB_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb cnt_d = (found_g && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign bus.grant_count[k] = cnt_q;
`endif
  end

  logic [NCONSUMERS-1:0] grants_c;

  always_comb begin
    grants_c = '0;
    for (int k = 0; k < NKERNELS; k++) grants_c = grants_c | gvec_all[k];
  end

  assign bus.grants = grants_c;

  logic [VALUE_WIDTH-1:0] responses_q [NCONSUMERS];
  logic [VALUE_WIDTH-1:0] responses_d [NCONSUMERS];
  logic [NCONSUMERS-1:0]  resp_valid_q, resp_valid_d;

  // Port priority guarantees distinct consumers across kernels on any one cycle.
  always_comb begin
    responses_d  = responses_q;
    resp_valid_d = '0;
    for (int k = 0; k < NKERNELS; k++) begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (exit_v[k] && exit_id[k] == MAX_ID_W'(c)) begin
          responses_d[c]  = bus.plm_outputs[k];
          resp_valid_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= '0;
      for (int c = 0; c < NCONSUMERS; c++) responses_q[c] <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      for (int c = 0; c < NCONSUMERS; c++) responses_q[c] <= responses_d[c];
    end
  end

  assign bus.responses      = responses_q;
  assign bus.response_valid = resp_valid_q;

endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Bench for rr_bank_arbiter: default, dual-port and three-consumer instances
// driven with directed vectors; read responses checked through a scoreboard.
module tb_rr_bank_arbiter;
  import rr_arb_pkg::*;

  localparam int AW    = 4;
  localparam int VW    = 8;
  localparam int REQ_W = req_width(AW, VW);
  localparam int PIN_W = plm_input_width(AW, 2, VW);
  localparam int W     = 26;  // {cycle[15:0], consumer[1:0], data[7:0]}

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e, mon_got;

  rr_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(4), .NBANKS(2), .NPORTS(1)) bus_a ();
  rr_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(4), .NBANKS(2), .NPORTS(2)) bus_b ();
  rr_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(3), .NBANKS(2), .NPORTS(1)) bus_c ();

  rr_bank_arbiter #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(4), .NBANKS(2), .NPORTS(1),
                    .PLM_LATENCY(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  rr_bank_arbiter #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(4), .NBANKS(2), .NPORTS(2),
                    .PLM_LATENCY(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
  rr_bank_arbiter #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(3), .NBANKS(2), .NPORTS(1),
                    .PLM_LATENCY(1)) dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c));

  // PLM stand-in for instance A: bank 0 returns 0x30+local, bank 1 returns 0xA4+local.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n)             bus_a.plm_outputs[k] <= 8'h00;
      else if (bus_a.plm_en[k]) bus_a.plm_outputs[k] <= ((k == 1) ? 8'hA4 : 8'h30) + {5'b0, bus_a.plm_inputs[k][PIN_W-1 -: 3]};
      else                      bus_a.plm_outputs[k] <= 8'h00;
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) bus_b.plm_outputs[k] = '0;
    for (int k = 0; k < 2; k++) bus_c.plm_outputs[k] = '0;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [REQ_W-1:0] mk_req(input logic [3:0] addr, input logic [7:0] val, input logic wr);
    return {addr, val, wr, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int c = 0; c < 4; c++) begin
      bus_a.requests[c] = '0;
      bus_b.requests[c] = '0;
    end
    for (int c = 0; c < 3; c++) bus_c.requests[c] = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      for (int c = 0; c < 4; c++) begin
        if (bus_a.response_valid[c]) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL resp_unexpected: consumer %0d data %0h at cycle %0d, none expected",
                     c, bus_a.responses[c], cyc);
          end else begin
            mon_e   = exp_q.pop_front();
            mon_got = {16'(cyc), 2'(c), bus_a.responses[c]};
            if (mon_got !== mon_e) begin
              bad++;
              $display("FAIL resp_a: got cyc=%0d id=%0d data=%0h expected cyc=%0d id=%0d data=%0h",
                       mon_got[25:10], mon_got[9:8], mon_got[7:0], mon_e[25:10], mon_e[9:8], mon_e[7:0]);
            end
          end
        end
      end
      check("resp_bc_none", {bus_b.response_valid, bus_c.response_valid}, 0);
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: run did not complete, got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    clear_reqs();
    reset_n = 1'b0;

    // Requests present during reset must not be granted.
    bus_a.requests[0] = mk_req(4'h2, 8'h00, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("rst_grants", bus_a.grants, 0);
      check("rst_plm_en", bus_a.plm_en, 0);
    end
    tick();
    clear_reqs();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {bus_a.grants, bus_a.plm_en, bus_a.response_valid}, 0);
    end

    // Fairness on bank 0 (pivot 0 after reset).
    tick();
    for (int c = 0; c < 4; c++) bus_a.requests[c] = mk_req(4'h2, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fair_grant", bus_a.grants, 32'(1 << (i % 4)));
      exp_q.push_back({16'(cyc + 2), 2'(i % 4), 8'h32});
      tick();
    end
    clear_reqs();
    drain("fair_drain");

    // Bank 1 starts at pivot 1.
    tick();
    for (int c = 0; c < 4; c++) bus_a.requests[c] = mk_req(4'hA, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bank1_grant", bus_a.grants, 32'(1 << ((i + 1) % 4)));
      exp_q.push_back({16'(cyc + 2), 2'((i + 1) % 4), 8'hA6});
      tick();
    end
    clear_reqs();
    drain("bank1_drain");

    // Routing: consumer 2 reads 0x9 -> bank 1, local 1.
    tick();
    bus_a.requests[2] = mk_req(4'h9, 8'h00, 1'b0);
    @(negedge clk);
    check("route_plm_en", bus_a.plm_en, 2'b10);
    check("route_plm_in", bus_a.plm_inputs[1], 12'h200);
    check("route_grant", bus_a.grants, 4'b0100);
    exp_q.push_back({16'(cyc + 2), 2'd2, 8'hA5});
    tick();
    clear_reqs();
    drain("route_drain");

    // Write: forwarded to the PLM, no response.
    tick();
    bus_a.requests[1] = mk_req(4'h3, 8'h77, 1'b1);
    @(negedge clk);
    check("wr_plm_en", bus_a.plm_en, 2'b01);
    check("wr_plm_in", bus_a.plm_inputs[0], 12'h6EF);
    check("wr_grant", bus_a.grants, 4'b0010);
    tick();
    clear_reqs();
    drain("wr_drain");

    // Two banks answer in the same cycle.
    tick();
    bus_a.requests[0] = mk_req(4'h5, 8'h00, 1'b0);
    bus_a.requests[3] = mk_req(4'hF, 8'h00, 1'b0);
    @(negedge clk);
    check("simul_grant", bus_a.grants, 4'b1001);
    exp_q.push_back({16'(cyc + 2), 2'd0, 8'h35});
    exp_q.push_back({16'(cyc + 2), 2'd3, 8'hAB});
    tick();
    clear_reqs();
    drain("simul_drain");

    // Reset while a read is in flight: it must be dropped.
    tick();
    bus_a.requests[0] = mk_req(4'h1, 8'h00, 1'b0);
    @(negedge clk);
    check("midrst_grant", bus_a.grants, 4'b0001);
    tick();
    clear_reqs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_rv", bus_a.response_valid, 0);
    end

    // Dual port: both ports of bank 0 serve distinct consumers together.
    tick();
    bus_b.requests[0] = mk_req(4'h1, 8'h11, 1'b1);
    bus_b.requests[1] = mk_req(4'h2, 8'h22, 1'b1);
    @(negedge clk);
    check("dual_grant", bus_b.grants, 4'b0011);
    check("dual_plm_en", bus_b.plm_en, 4'b0011);
    check("dual_in_p0", bus_b.plm_inputs[0], 12'h223);
    check("dual_in_p1", bus_b.plm_inputs[1], 12'h445);
    tick();
    bus_b.requests[0] = mk_req(4'h1, 8'h11, 1'b1);
    bus_b.requests[1] = mk_req(4'h2, 8'h22, 1'b1);
    bus_b.requests[2] = mk_req(4'h3, 8'h33, 1'b1);
    @(negedge clk);
    check("dual_grant2", bus_b.grants, 4'b0110);
    tick();
    bus_b.requests[1] = '0;
    bus_b.requests[2] = '0;
    @(negedge clk);
    check("dual_grant3", bus_b.grants, 4'b0001);
    check("dual_plm_en3", bus_b.plm_en, 4'b0001);
    tick();
    clear_reqs();
    repeat (3) @(negedge clk);

    // Three consumers: pivot wraps from 2 to 0.
    tick();
    bus_c.requests[1] = mk_req(4'h0, 8'h01, 1'b1);
    @(negedge clk);
    check("wrap_set", bus_c.grants, 3'b010);
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int c = 0; c < 3; c++) bus_c.requests[c] = mk_req(4'h0, 8'h01, 1'b1);
      @(negedge clk);
      check("wrap_grant", bus_c.grants, 32'(1 << ((i + 2) % 3)));
    end
    tick();
    clear_reqs();
    repeat (3) @(negedge clk);

    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
